display_scan_controller: RTL and testbench
==========================================

// Module: display_scan_controller
// PURPOSE
//  Time-multiplexed scan sequencer for the 8-digit seven-segment display. Walks anum 0..7 and
//  presents the matching BCD nibble on v to the BCD decoder; a guard interval between digits
//  suppresses ghosting. Stopwatch logic writes all 8 digits into a shadow buffer; the shadow
//  is copied to the scan buffer only at a frame boundary, so a frame never mixes old and new digits.
// PARAMETERS
//  DWELL_CYCLES  100000  clocks each digit is driven (100 MHz -> 1 ms/digit, 125 Hz frame); >=2
//  GUARD_CYCLES  500     clocks blanked between digits; 0 = no guard state
//  CNT_W         17      cycle counter width; must hold max(DWELL_CYCLES,GUARD_CYCLES)-1
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-high reset
//  enable       in   1   1 = scan; 0 = finish current digit's GUARD, then IDLE
//  digits_in    in   32  digit k = digits_in[4k+3:4k]; digit 0 = rightmost (anum 0)
//  load         in   1   1-cycle request: capture digits_in into shadow buffer
//  blank_mask   in   8   bit k = 1 forces digit k blank (leading-zero suppression), sampled live
//  load_ack     out  1   1-cycle pulse when shadow is committed to scan buffer
//  v            out  4   BCD nibble of current digit (to decoder v)
//  anum         out  3   current digit index (to decoder anum)
//  blank        out  1   1 = top level forces an = 8'hFF this cycle
//  frame_done   out  1   1-cycle pulse on the last cycle of digit 7 (DWELL, or GUARD if enabled)
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, cnt=0, anum=0, v=0, blank=1, load_ack=0,
//   frame_done=0, pending=0, scan buffer=0, shadow=0.
//  States: IDLE, DWELL, GUARD. All outputs registered.
//   IDLE : blank=1, anum=0. If enable -> DWELL with anum=0, cnt=0 next cycle.
//   DWELL: blank=blank_mask[anum]; v=scan_buf[anum]. cnt counts 0..DWELL_CYCLES-1; at terminal
//          count -> GUARD (or straight to next digit if GUARD_CYCLES==0).
//   GUARD: blank=1; cnt 0..GUARD_CYCLES-1; at terminal -> anum+1 (7 wraps to 0), DWELL;
//          if enable==0 at terminal -> IDLE.
//  Frame boundary = terminal cycle of digit 7's final state. Wrap 7->0 is mod-8, no extra cycle.
//  Load handshake:
//   - load=1 copies digits_in to shadow, sets pending=1; repeated loads before commit overwrite
//     shadow (latest wins), only one load_ack results.
//   - Commit at frame boundary if pending: scan_buf<=shadow, pending<=0, load_ack=1 next cycle,
//     coincident with frame_done pulse edge; new data first visible on anum=0 of next frame.
//   - In IDLE, pending commits the cycle after load (ack latency 2 clocks from load).
//   - load on the same cycle as a commit: commit uses old shadow; new data captured, pending
//     stays 1 for the next frame.
//  enable dropped mid-DWELL: current digit completes DWELL+GUARD, then IDLE; no partial frame
//   commit unless that digit is 7. Re-enable always restarts at anum=0.
//  reset mid-scan: immediate blank=1, anum=0; pending data lost.
//  blank_mask changes take effect next cycle, no frame alignment.
// STRUCTURE
//  Shared package (display_pkg): state encoding localparams (S_IDLE/S_DWELL/S_GUARD),
//   NUM_DIGITS=8, DIGIT_W=4, default DWELL/GUARD constants.
//  One sub-module: scan_timer (loadable down-counter, terminal-count flag) reused for
//   DWELL and GUARD. Digit mux and buffers stay in the top.
//  Top level instantiates this block feeding the existing BCD decoder; an gated by blank.
// TESTING (DWELL_CYCLES=4, GUARD_CYCLES=2 for sim)
//  1 reset, enable=1, scan_buf=0 -> anum 0..7 each 4 cycles unblanked + 2 blank; frame_done
//    every 48 cycles; anum wraps 7->0.
//  2 load 32'h8765_4321 mid-digit 3 -> v unchanged until frame boundary; load_ack 1 pulse;
//    next frame v=1,2,..8 at anum 0..7.
//  3 two loads (32'h1111_1111 then 32'h2222_2222) in one frame -> one load_ack, frame shows 2s;
//    load on commit cycle -> second ack one frame later.
//  4 enable=0 during DWELL of digit 5 -> DWELL+GUARD finish, IDLE (blank=1, anum=0);
//    re-enable -> scan resumes at anum 0.
//  5 blank_mask=8'hF0 -> blank=1 during DWELL of anum 4..7, 0 for 0..3.
//  6 reset asserted mid-DWELL with pending load -> outputs at reset values same cycle
//    (async); no load_ack after release; scan_buf=0.

Source files
------------

// File: rtl/display_scan_controller_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package display_scan_controller_pkg;

    // Scan sequencer states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1,
        S_GUARD = 2'd2
    } scan_state_e;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 4;
    localparam int ANUM_W     = 3;
    localparam int BUF_W      = NUM_DIGITS * DIGIT_W;

    // Defaults for a 100 MHz clock: 1 ms per digit, 5 us blanking between digits.
    localparam int DEFAULT_DWELL_CYCLES = 100000;
    localparam int DEFAULT_GUARD_CYCLES = 500;
    localparam int DEFAULT_CNT_W        = 17;

endpackage

// File: rtl/display_scan_controller_if.sv
// Bus between the stopwatch/decoder side and the scan controller.
interface display_scan_controller_if;
    import display_scan_controller_pkg::*;

    logic                 enable;
    logic [BUF_W-1:0]     digits_in;
    logic                 load;
    logic [NUM_DIGITS-1:0] blank_mask;
    logic                 load_ack;
    logic [DIGIT_W-1:0]   v;
    logic [ANUM_W-1:0]    anum;
    logic                 blank;
    logic                 frame_done;

    // Client side: drives control and digit data, observes the scan outputs.
    modport master (
        output enable, digits_in, load, blank_mask,
        input  load_ack, v, anum, blank, frame_done
    );

    // Controller side.
    modport slave (
        input  enable, digits_in, load, blank_mask,
        output load_ack, v, anum, blank, frame_done
    );
endinterface

// File: rtl/display_scan_controller_scan_timer.sv
// Loadable down-counter shared by the DWELL and GUARD intervals.
// tc flags the terminal (zero) count this cycle; tc_next flags that the
// count about to be registered is terminal, so the owner can register
// outputs that line up with the terminal cycle.
module display_scan_controller_scan_timer #(
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc,
    output logic             tc_next
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload, else count down and hold at zero.
    always_comb begin
        // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc      = (cnt_q == '0);
    assign tc_next = (cnt_d == '0);

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed scan sequencer for an 8-digit seven-segment display.
// Walks anum 0..7 with a blanked guard interval between digits. Digits are
// double-buffered: loads land in a shadow buffer that is committed to the
// scan buffer only at a frame boundary (or immediately while idle), so a
// displayed frame never mixes old and new digits.
module display_scan_controller
    import display_scan_controller_pkg::*;
#(
    parameter int DWELL_CYCLES = DEFAULT_DWELL_CYCLES,
    parameter int GUARD_CYCLES = DEFAULT_GUARD_CYCLES,
    parameter int CNT_W        = DEFAULT_CNT_W
) (
    input  logic                        clk,
    input  logic                        reset,
    display_scan_controller_if.slave    bus
);

    localparam bit                HAS_GUARD    = (GUARD_CYCLES > 0);
    localparam int                GUARD_LOAD_I = HAS_GUARD ? GUARD_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0]  DWELL_LOAD   = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GUARD_LOAD   = CNT_W'(GUARD_LOAD_I);
    localparam logic [ANUM_W-1:0] LAST_DIGIT   = ANUM_W'(NUM_DIGITS - 1);
    localparam logic [ANUM_W-1:0] ANUM_ONE     = ANUM_W'(1);

    scan_state_e          state_q, state_d;
    logic [ANUM_W-1:0]    anum_q, anum_d;
    logic [BUF_W-1:0]     scan_buf_q, scan_buf_d;
    logic [BUF_W-1:0]     shadow_q, shadow_d;
    logic                 pending_q, pending_d;
    logic [DIGIT_W-1:0]   v_q, v_d;
    logic                 blank_q, blank_d;
    logic                 load_ack_q, load_ack_d;
    logic                 frame_done_q, frame_done_d;

    logic                 timer_load;
    logic [CNT_W-1:0]     timer_val;
    logic                 timer_tc;
    logic                 timer_tc_next;
    logic                 commit;

    display_scan_controller_scan_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .tc       (timer_tc),
        .tc_next  (timer_tc_next)
    );

    // Sequencer: digit index, state and interval timer reloads.
    always_comb begin
        state_d    = state_q;
        anum_d     = anum_q;
        timer_load = 1'b0;
        timer_val  = DWELL_LOAD;
        case (state_q)
            S_IDLE: begin
                anum_d = '0;
                if (bus.enable) begin
                    state_d    = S_DWELL;
                    timer_load = 1'b1;
                end
            end
            S_DWELL: begin
                if (timer_tc) begin
                    if (HAS_GUARD) begin
                        state_d    = S_GUARD;
                        timer_load = 1'b1;
                        timer_val  = GUARD_LOAD;
                    end else if (bus.enable) begin
                        anum_d     = anum_q + ANUM_ONE;
                        timer_load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        anum_d  = '0;
                    end
                end
            end
            S_GUARD: begin
                if (timer_tc) begin
                    if (bus.enable) begin
                        state_d    = S_DWELL;
                        anum_d     = anum_q + ANUM_ONE;
                        timer_load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        anum_d  = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                anum_d  = '0;
            end
        endcase
    end

    // Buffers and load handshake; frame_done_q marks the frame-boundary cycle.
    always_comb begin
        commit     = pending_q && (frame_done_q || (state_q == S_IDLE));
        scan_buf_d = commit ? shadow_q : scan_buf_q;
        shadow_d   = bus.load ? bus.digits_in : shadow_q;
        pending_d  = bus.load || (pending_q && !commit);
        load_ack_d = commit;
    end

    // Registered outputs, computed from the next-cycle view so they align with state_q.
    always_comb begin
        blank_d      = (state_d == S_DWELL) ? bus.blank_mask[anum_d] : 1'b1;
        v_d          = scan_buf_d[{anum_d, 2'b00} +: DIGIT_W];
        frame_done_d = (anum_d == LAST_DIGIT) && timer_tc_next &&
                       ((state_d == S_GUARD) || ((state_d == S_DWELL) && !HAS_GUARD));
    end

    // State, buffer and output registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the digit buffers are reset too, so a reset always restarts from a blank, zeroed display.
        if (reset) begin
            state_q      <= S_IDLE;
            anum_q       <= '0;
            scan_buf_q   <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            v_q          <= '0;
            blank_q      <= 1'b1;
            load_ack_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            anum_q       <= anum_d;
            scan_buf_q   <= scan_buf_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            v_q          <= v_d;
            blank_q      <= blank_d;
            load_ack_q   <= load_ack_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.v          = v_q;
    assign bus.anum       = anum_q;
    assign bus.blank      = blank_q;
    assign bus.load_ack   = load_ack_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller (DWELL=4, GUARD=2).
// A behavioural model tracks the scan as a slot of DWELL+GUARD cycles per
// digit and holds the frames as digit arrays; outputs are compared every cycle.
module tb_display_scan_controller;

    localparam int D     = 4;
    localparam int G     = 2;
    localparam int SLOT  = D + G;
    localparam int FRAME = 8 * SLOT;

    logic clk = 1'b0;
    logic reset;

    display_scan_controller_if bus_if ();

    display_scan_controller #(
        .DWELL_CYCLES (D),
        .GUARD_CYCLES (G),
        .CNT_W        (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int ack_cnt = 0;
    int unblank_cnt = 0;
    string phase = "init";

    // Reference model state.
    bit   m_run;
    int   m_d;
    int   m_s;
    bit   m_pend;
    int   m_shadow[8];
    int   m_buf[8];
    logic [2:0] e_anum;
    logic [3:0] e_v;
    logic e_blank, e_fd, e_ack;
    bit   e_v_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_d = 0; m_s = 0; m_pend = 0;
        for (int k = 0; k < 8; k++) begin
            m_shadow[k] = 0;
            m_buf[k]    = 0;
        end
        e_anum = 3'd0; e_v = 4'd0; e_blank = 1'b1; e_fd = 1'b0; e_ack = 1'b0; e_v_valid = 0;
    endtask

    // One clock edge of the scan rules, using the inputs present before the edge.
    task automatic model_step();
        bit commit;
        commit = m_pend && (e_fd || !m_run);
        if (commit) begin
            for (int k = 0; k < 8; k++) m_buf[k] = m_shadow[k];
            m_pend = 0;
        end
        if (bus_if.load) begin
            for (int k = 0; k < 8; k++) m_shadow[k] = int'(bus_if.digits_in[4*k +: 4]);
            m_pend = 1;
        end
        if (!m_run) begin
            if (bus_if.enable) begin
                m_run = 1; m_d = 0; m_s = 0;
            end
        end else if (m_s == SLOT - 1) begin
            if (bus_if.enable) begin
                m_d = (m_d + 1) % 8; m_s = 0;
            end else begin
                m_run = 0; m_d = 0; m_s = 0;
            end
        end else begin
            m_s++;
        end
        e_anum    = 3'(m_d);
        e_ack     = commit;
        e_fd      = m_run && (m_d == 7) && (m_s == SLOT - 1);
        e_v_valid = m_run && (m_s < D);
        e_blank   = e_v_valid ? bus_if.blank_mask[m_d] : 1'b1;
        e_v       = 4'(m_buf[m_d]);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".anum"},       32'(bus_if.anum),       32'(e_anum));
        chk({tag, ".blank"},      32'(bus_if.blank),      32'(e_blank));
        chk({tag, ".frame_done"}, 32'(bus_if.frame_done), 32'(e_fd));
        chk({tag, ".load_ack"},   32'(bus_if.load_ack),   32'(e_ack));
        if (e_v_valid) chk({tag, ".v"}, 32'(bus_if.v), 32'(e_v));
    endtask

    // Advance one clock; compare on the falling edge, inputs change afterwards.
    task automatic cycle();
        @(posedge clk);
        if (reset) model_reset(); else model_step();
        @(negedge clk);
        check_all(phase);
        if (bus_if.load_ack === 1'b1) ack_cnt++;
        if (bus_if.blank === 1'b0) unblank_cnt++;
    endtask

    task automatic wait_slot(input int dig, input int s, input string tag);
        int n = 0;
        while (!(m_run && m_d == dig && m_s == s) && n < 200) begin
            cycle();
            n++;
        end
        n_vec++;
        assert (n < 200) else begin
            n_err++;
            $error("FAIL %s: wait budget expired after %0d cycles, required < 200", tag, n);
        end
    endtask

    task automatic wait_fd(input string tag);
        int n = 0;
        while (!e_fd && n < 200) begin
            cycle();
            n++;
        end
        n_vec++;
        assert (n < 200) else begin
            n_err++;
            $error("FAIL %s: wait budget expired after %0d cycles, required < 200", tag, n);
        end
    endtask

    task automatic pulse_load(input logic [31:0] val);
        bus_if.digits_in = val;
        bus_if.load = 1'b1;
        cycle();
        bus_if.load = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        bus_if.enable = 1'b0;
        bus_if.load = 1'b0;
        bus_if.digits_in = '0;
        bus_if.blank_mask = '0;
        model_reset();

        // Reset state.
        phase = "rst";
        repeat (3) cycle();
        chk("rst.v", 32'(bus_if.v), 32'd0);
        reset = 1'b0;
        repeat (2) cycle();

        // 1: free-running scan of a zeroed buffer, frame period and wrap.
        phase = "s1";
        bus_if.enable = 1'b1;
        wait_fd("s1.wait");
        n = 0;
        do begin
            cycle();
            n++;
        end while (bus_if.frame_done !== 1'b1 && n < 200);
        chk("s1.fd_period", 32'(n), 32'(FRAME));
        cycle();
        chk("s1.wrap_anum", 32'(bus_if.anum), 32'd0);

        // 2: load mid-digit 3 is held until the frame boundary.
        phase = "s2";
        wait_slot(3, 1, "s2.wait");
        ack_cnt = 0;
        pulse_load(32'h8765_4321);
        repeat (2 * FRAME) cycle();
        chk("s2.acks", 32'(ack_cnt), 32'd1);

        // 3: two loads in one frame -> one ack, latest wins.
        phase = "s3";
        wait_slot(1, 0, "s3.wait");
        ack_cnt = 0;
        pulse_load(32'h1111_1111);
        repeat (5) cycle();
        pulse_load(32'h2222_2222);
        repeat (2 * FRAME) cycle();
        chk("s3.acks_two_loads", 32'(ack_cnt), 32'd1);
        // Load on the commit cycle: commit takes the older shadow, next frame the new one.
        wait_slot(2, 0, "s3.wait2");
        ack_cnt = 0;
        pulse_load($urandom);
        wait_fd("s3.wait_fd");
        pulse_load($urandom);
        repeat (FRAME + 5) cycle();
        chk("s3.acks_commit_cycle", 32'(ack_cnt), 32'd2);

        // 4: enable dropped during digit 5 dwell, then re-enable.
        phase = "s4";
        wait_slot(5, 1, "s4.wait");
        bus_if.enable = 1'b0;
        repeat (SLOT + 6) cycle();
        chk("s4.idle_blank", 32'(bus_if.blank), 32'd1);
        chk("s4.idle_anum",  32'(bus_if.anum),  32'd0);
        bus_if.enable = 1'b1;
        repeat (FRAME) cycle();

        // 5: upper four digits masked.
        phase = "s5";
        bus_if.blank_mask = 8'hF0;
        wait_fd("s5.wait");
        unblank_cnt = 0;
        repeat (FRAME) cycle();
        chk("s5.unblanked_cycles", 32'(unblank_cnt), 32'(4 * D));
        bus_if.blank_mask = 8'h00;

        // 6: async reset mid-dwell with a pending load.
        phase = "s6";
        wait_slot(2, 1, "s6.wait");
        pulse_load($urandom | 32'h1111_1111);
        #2 reset = 1'b1;
        #1 model_reset();
        check_all("s6.async");
        chk("s6.async.v", 32'(bus_if.v), 32'd0);
        repeat (2) cycle();
        reset = 1'b0;
        ack_cnt = 0;
        repeat (2 * FRAME) cycle();
        chk("s6.no_ack", 32'(ack_cnt), 32'd0);

        // Randomised traffic against the model.
        phase = "rand";
        for (int i = 0; i < 3000; i++) begin
            bus_if.enable = ($urandom_range(0, 63) != 0);
            bus_if.load   = ($urandom_range(0, 19) == 0);
            bus_if.digits_in = $urandom;
            if ($urandom_range(0, 49) == 0) bus_if.blank_mask = 8'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
